branch_tag_scheduler: RTL

- Allocates branch-stack slots (branch tags) to branches in each dispatch group and tracks the outstanding branch mask.
- Keeps a per-tag dependency matrix, so a mispredict frees the mispredicted tag and every younger dependent tag.
- Sequences the one-cycle recovery window. During that window it pulses the restore valids to fetch/ROB/free list/map table and holds dispatch.
- Sits between dispatch and the branch stack; it is the sole owner of tag allocation.

---
 rtl/branch_tag_scheduler.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/branch_tag_scheduler.sv
// Branch tag scheduler: hands out branch-stack tags to the branches of a
// dispatch group, tracks which tags are outstanding and which older tags each
// one depends on, and sequences the one-cycle recovery window after a
// mispredict.
module branch_tag_scheduler #(
  parameter int B_MASK_WIDTH   = 4,
  parameter int DISPATCH_WIDTH = 2
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [DISPATCH_WIDTH-1:0]                branch_req,
  input  logic [DISPATCH_WIDTH-1:0]                inst_valid,
  input  logic [B_MASK_WIDTH-1:0]                  b_mm_resolve,
  input  logic                                     b_mm_mispred,
  output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0]   grant_tag,
  output logic [DISPATCH_WIDTH-1:0]                grant_valid,
  output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0]   inst_b_mask,
  output logic [B_MASK_WIDTH-1:0]                  b_mask_outstanding,
  output logic [$clog2(B_MASK_WIDTH+1)-1:0]        free_count,
  output logic [B_MASK_WIDTH-1:0]                  restore_tag,
  output logic                                     restore_valid,
  output logic                                     dispatch_stall
);

  localparam int W  = B_MASK_WIDTH;
  localparam int N  = DISPATCH_WIDTH;
  localparam int CW = $clog2(B_MASK_WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // Isolate the lowest set bit of a tag vector (0 if none set).
  function automatic logic [W-1:0] lowest_one(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!found && v[i]) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end else begin
        r[i]  = 1'b0;
      end
    end
    return r;
  endfunction

  // Number of set bits in a tag vector.
  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Registered state.
  state_t                 state_r, state_n;
  logic [W-1:0]           outstanding_r, outstanding_n;
  logic [W-1:0][W-1:0]    dep_r, dep_n;          // dep_r[i][j]: tag i younger than and dependent on tag j
  logic [W-1:0]           restore_tag_r, restore_tag_n;
  logic [CW-1:0]          free_count_r;

  // Resolve decode.
  logic [W-1:0]           hit_s;          // resolving tag, only if it is outstanding
  logic [W-1:0]           corr_s;         // correctly resolving tag
  logic [W-1:0]           squash_s;       // mispredicted tag plus its dependents
  logic [W-1:0]           base_mask_s;
  logic                   mispred_s;
  logic                   suppress_s;

  // Grant path.
  logic [N-1:0][W-1:0]    grant_tag_s;
  logic [N-1:0][W-1:0]    alloc_dep_s;
  logic [N-1:0][W-1:0]    inst_mask_s;
  logic [N-1:0]           grant_valid_s;
  logic [W-1:0]           taken_s;
  logic [W-1:0]           pick_s;
  logic                   blocked_s;
  logic                   stall_s;

  // Decode this cycle's resolve: correct vs. mispredict and the squash set.
  always_comb begin
    hit_s     = b_mm_resolve & outstanding_r;
    mispred_s = b_mm_mispred & (|hit_s);
    if (b_mm_mispred) begin
      corr_s = '0;
    end else begin
      corr_s = hit_s;
    end
    base_mask_s = outstanding_r & ~corr_s;
    // A mispredict flag with any resolve bit blocks grants even if the tag is stale.
    suppress_s  = reset | (state_r == RECOVER) | (b_mm_mispred & (|b_mm_resolve));
    squash_s    = hit_s;
    for (int i = 0; i < W; i++) begin
      if ((dep_r[i] & hit_s) != '0) begin
        squash_s[i] = 1'b1;
      end else begin
        squash_s[i] = hit_s[i];
      end
    end
  end

  // Walk the dispatch slots oldest first, granting the lowest free tags in order.
  always_comb begin
    grant_tag_s   = '0;
    grant_valid_s = '0;
    alloc_dep_s   = '0;
    inst_mask_s   = '0;
    taken_s       = '0;
    pick_s        = '0;
    blocked_s     = 1'b0;
    stall_s       = suppress_s;
    for (int k = 0; k < N; k++) begin
      // Older same-group grants are part of the mask a younger slot carries.
      alloc_dep_s[k] = base_mask_s | taken_s;
      if (inst_valid[k]) begin
        inst_mask_s[k] = base_mask_s | taken_s;
      end else begin
        inst_mask_s[k] = '0;
      end
      if (branch_req[k] && inst_valid[k] && !suppress_s) begin
        // Only registered outstanding counts: tags freed this cycle wait a cycle.
        pick_s = lowest_one(~outstanding_r & ~taken_s);
        if (blocked_s || (pick_s == '0)) begin
          blocked_s = 1'b1;
          stall_s   = 1'b1;
        end else begin
          grant_tag_s[k]   = pick_s;
          grant_valid_s[k] = 1'b1;
          taken_s          = taken_s | pick_s;
        end
      end else begin
        pick_s = '0;
      end
    end
  end

  // Next outstanding mask, dependency matrix and restore tag.
  always_comb begin
    outstanding_n = outstanding_r;
    dep_n         = dep_r;
    restore_tag_n = restore_tag_r;
    if (mispred_s) begin
      outstanding_n = outstanding_r & ~squash_s;
      for (int i = 0; i < W; i++) begin
        if (squash_s[i]) begin
          dep_n[i] = '0;
        end else begin
          dep_n[i] = dep_r[i] & ~squash_s;
        end
      end
      restore_tag_n = hit_s;
    end else begin
      outstanding_n = outstanding_r & ~corr_s;
      for (int i = 0; i < W; i++) begin
        if (corr_s[i]) begin
          dep_n[i] = '0;
        end else begin
          dep_n[i] = dep_r[i] & ~corr_s;
        end
      end
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < W; i++) begin
          if (grant_tag_s[k][i]) begin
            outstanding_n[i] = 1'b1;
            dep_n[i]         = alloc_dep_s[k];
          end else begin
            dep_n[i]         = dep_n[i];
          end
        end
      end
    end
  end

  // Recovery FSM next state: a valid mispredict (re)enters RECOVER for one cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (mispred_s) begin
          state_n = RECOVER;
        end else begin
          state_n = IDLE;
        end
      end
      RECOVER: begin
        if (mispred_s) begin
          state_n = RECOVER;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      outstanding_r <= '0;
      dep_r         <= '0;
      restore_tag_r <= '0;
      free_count_r  <= CW'(W);
    end else begin
      state_r       <= state_n;
      outstanding_r <= outstanding_n;
      dep_r         <= dep_n;
      restore_tag_r <= restore_tag_n;
      free_count_r  <= popcount(~outstanding_n);
    end
  end

  assign grant_tag          = grant_tag_s;
  assign grant_valid        = grant_valid_s;
  assign inst_b_mask        = inst_mask_s;
  assign dispatch_stall     = stall_s;
  assign b_mask_outstanding = outstanding_r;
  assign free_count         = free_count_r;
  assign restore_tag        = restore_tag_r;
  assign restore_valid      = (state_r == RECOVER);

endmodule
